lab3_pattern_ctrl: RTL
======================

# lab3_pattern_ctrl

Sequencer for the lab-3 DFF pattern bank. It owns a DFF_num-bit register and, on a start handshake, loads a seed and then steps it a programmed number of cycles in one of four modes: toggle, rotate-left, rotate-right or hold. It then reports completion. It replaces the free-running alternating-pattern bank wherever the pattern must be commanded rather than continuous.

## Interface
- DFF_num, 8, register width; must be even and ≥2
- CNT_W, 5, width of step-count input and internal counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  command request; sampled only in IDLE
- mode  input  2  00 toggle (q←~q), 01 rotate left, 10 rotate right, 11 hold
- seed  input  DFF_num  value loaded into q at command start
- len  input  CNT_W  number of step cycles after load (0..2^CNT_W−1)
- abort  input  1  cancel an in-progress command
- q  output  DFF_num  pattern register
- busy  output  1  high in LOAD, RUN, DONE
- done  output  1  one-cycle completion pulse (state DONE)
- One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Reset (asynchronous, immediate): q = alternating pattern, bit0=1 (0x55 for DFF_num=8); state IDLE; busy=0; done=0; counter=0; latched mode=00.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: q holds. On start=1 and abort=0, latch mode and len, capture seed, go to LOAD. start=1 together with abort=1: abort wins, stay IDLE.
- LOAD: q←seed; counter←len; go to RUN if len≠0, otherwise go to DONE.
- RUN: q←step(q, mode) every cycle; counter decrements. On the cycle the counter goes 1→0, go to DONE.
- DONE: q holds; done=1 for this cycle only; go to IDLE unconditionally.
- abort=1 in LOAD or RUN: go to IDLE at the next edge; q keeps its last value; no step or load on that edge; no done pulse. abort in IDLE or DONE has no effect.
- start in any state other than IDLE is ignored. It is not queued.
- Step rules: rotate left moves q[DFF_num−1] to q[0]; rotate right moves q[0] to q[DFF_num−1]; no carry or overflow. Hold keeps q unchanged but still counts cycles.
- Inputs mode, seed and len are don't-care except on the IDLE start edge.

## Timing
- Edge E0 samples start: state→LOAD; busy rises after E0.
- E1: q=seed visible after E1.
- E2..E(1+len): one step per edge; after E(1+len) state=DONE and done=1.
- E(2+len): state→IDLE; busy and done fall. Busy lasts exactly len+2 cycles.
- len=0: q=seed after E1, done high between E1 and E2.
- Earliest next start accepted at edge E(2+len) is not possible, because state is still DONE there. The next accepted start is at E(3+len). There is no back-to-back overlap.
- Reset mid-command: immediate return to reset values; done is not pulsed.

## Structure
- Package lab3_pattern_pkg holds:
  - mode encodings MODE_TOGGLE=2'b00, MODE_ROL=2'b01, MODE_ROR=2'b10, MODE_HOLD=2'b11;
  - the FSM state typedef (IDLE, LOAD, RUN, DONE, 2-bit);
  - the reset-pattern function for a given width.
- Sub-module lab3_pattern_step is purely combinational: (q, mode) → next q. The controller instantiates it once and contains the FSM, counter and register.

## Test plan
- Reset: hold rst_n=0 two cycles → q=0x55, busy=0, done=0. Assert rst_n mid-cycle → q changes without waiting for a clock edge.
- Toggle: start with mode=00, seed=0x55, len=4 → q sequence 55, AA, 55, AA, 55 after E1..E5; done=1 only between E5 and E6; busy high for 6 cycles.
- Rotate: mode=01, seed=0x81, len=3 → q = 81, 03, 06, 0C. Then mode=10, seed=0x01, len=2 → q = 01, 80, 40; done once per command.
- len=0 with mode=11, seed=0xA5 → q=A5 after E1, done between E1 and E2, busy for 2 cycles.
- Abort and ignore: mode=00, seed=0x0F, len=10; start pulsed again during RUN (ignored); abort after 3 steps (q=F0) → IDLE next edge, q stays F0, no done pulse. Then start and abort together in IDLE → no command.
- Reset mid-RUN of a mode=01, len=20 command → q=0x55, busy=0 immediately. A new command after rst_n releases runs normally.

Source files
------------

// File: rtl/lab3_pattern_pkg.sv
// ============================================================================
// Module   : lab3_pattern_pkg
// Purpose  : Shared mode encodings, FSM state type and reset pattern for the
//            lab-3 pattern sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lab3_pattern_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_ROR    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Alternating pattern with bit0=1, valid for widths up to 64.
  function automatic logic [63:0] reset_pattern(input int unsigned width);
    logic [63:0] p;
    p = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i < width) && (i % 2 == 0)) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab3_pattern_step.sv
// ============================================================================
// Module   : lab3_pattern_step
// Purpose  : Combinational single-step function of the pattern register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab3_pattern_step
  import lab3_pattern_pkg::*;
#(
  parameter int DFF_num = 8
) (
  input  logic [DFF_num-1:0] q,
  input  logic [1:0]         mode,
  output logic [DFF_num-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_TOGGLE: q_next = ~q;
      MODE_ROL:    q_next = {q[DFF_num-2:0], q[DFF_num-1]};
      MODE_ROR:    q_next = {q[0], q[DFF_num-1:1]};
      default:     q_next = q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lab3_pattern_ctrl.sv
// ============================================================================
// Module   : lab3_pattern_ctrl
// Purpose  : Commanded sequencer: loads a seed, steps it len cycles in the
//            latched mode, then pulses done. Abortable while busy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lab3_pattern_ctrl
  import lab3_pattern_pkg::*;
#(
  parameter int DFF_num = 8,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [DFF_num-1:0] seed,
  input  logic [CNT_W-1:0]   len,
  input  logic               abort,
  output logic [DFF_num-1:0] q,
  output logic               busy,
  output logic               done
);

  localparam logic [DFF_num-1:0] c_rst_q = DFF_num'(reset_pattern(DFF_num));

  state_t             r_state, w_state_nxt;
  logic [DFF_num-1:0] r_q, w_q_nxt;
  logic [DFF_num-1:0] r_seed, w_seed_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_len, w_len_nxt;
  logic [1:0]         r_mode, w_mode_nxt;
  logic [DFF_num-1:0] w_step_q;

  lab3_pattern_step #(
    .DFF_num (DFF_num)
  ) u_step (
    .q      (r_q),
    .mode   (r_mode),
    .q_next (w_step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_q     <= c_rst_q;
      r_seed  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= MODE_TOGGLE;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_seed  <= w_seed_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_seed_nxt  = r_seed;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_mode_nxt  = r_mode;
    case (r_state)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          w_mode_nxt  = mode;
          w_len_nxt   = len;
          w_seed_nxt  = seed;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_q_nxt     = r_seed;
          w_cnt_nxt   = r_len;
          w_state_nxt = (r_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_q_nxt   = w_step_q;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign q    = r_q;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule

`default_nettype wire
